// File: rtl/gemm_issue_ctrl.sv
// Execute-stage sequencer for the custom-0 GEMM accelerator: latches configuration,
// launches runs while holding the pipeline stall, and returns status/cycle readback.
module gemm_issue_ctrl #(
  parameter int          DIM_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_exec,
  input  logic             inst_valid,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             acc_busy,
  input  logic             acc_done,
  output logic             gemm_stall,
  output logic             acc_start,
  output logic [31:0]      acc_addr_a,
  output logic [31:0]      acc_addr_b,
  output logic [31:0]      acc_addr_c,
  output logic [DIM_W-1:0] acc_dim_m,
  output logic [DIM_W-1:0] acc_dim_n,
  output logic [DIM_W-1:0] acc_dim_k,
  output logic             rd_wr,
  output logic [31:0]      rd_wdata,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  localparam logic [6:0]  GEMM_OPCODE = 7'b0001011;
  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

  state_t      state;
  logic        stall_q;
  logic [31:0] run_cnt;
  logic [31:0] cycles_q;
  logic [31:0] next_cnt;
  logic [31:0] n_ext;
  logic [2:0]  funct3;
  logic        is_gemm;
  logic        in_idle;
  logic        dec_cfg_a, dec_cfg_b, dec_cfg_c, dec_cfg_dim;
  logic        dec_start, dec_status, dec_cycles;
  logic        unused_ok;

  // Decode is only honoured in IDLE, which also keeps RELEASE from re-issuing START.
  assign is_gemm     = inst_valid && (inst_exec[6:0] == GEMM_OPCODE);
  assign funct3      = inst_exec[14:12];
  assign in_idle     = (state == IDLE);
  assign dec_cfg_a   = in_idle && is_gemm && (funct3 == 3'b000);
  assign dec_cfg_b   = in_idle && is_gemm && (funct3 == 3'b001);
  assign dec_cfg_c   = in_idle && is_gemm && (funct3 == 3'b010);
  assign dec_cfg_dim = in_idle && is_gemm && (funct3 == 3'b011);
  assign dec_start   = in_idle && is_gemm && (funct3 == 3'b100);
  assign dec_status  = in_idle && is_gemm && (funct3 == 3'b101);
  assign dec_cycles  = in_idle && is_gemm && (funct3 == 3'b110);

  assign next_cnt = (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
  assign n_ext    = {16'b0, rs1_data[31:16]};

  assign gemm_stall = dec_start || stall_q;
  assign rd_wr      = dec_status || dec_cycles;

  assign unused_ok = ^{inst_exec, rs2_data, n_ext};

  always_comb begin
    rd_wdata = '0;
    if (dec_status)
      rd_wdata = {29'b0, err, !in_idle, acc_busy};
    else if (dec_cycles)
      rd_wdata = cycles_q;
  end

  // The latched cycle count includes the exit cycle, hence next_cnt rather than run_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stall_q    <= 1'b0;
      acc_start  <= 1'b0;
      err        <= 1'b0;
      acc_addr_a <= '0;
      acc_addr_b <= '0;
      acc_addr_c <= '0;
      acc_dim_m  <= '0;
      acc_dim_n  <= '0;
      acc_dim_k  <= '0;
      run_cnt    <= '0;
      cycles_q   <= '0;
    end else begin
      acc_start <= 1'b0;
      case (state)
        IDLE: begin
          if (dec_cfg_a) acc_addr_a <= rs1_data;
          if (dec_cfg_b) acc_addr_b <= rs1_data;
          if (dec_cfg_c) acc_addr_c <= rs1_data;
          if (dec_cfg_dim) begin
            acc_dim_m <= rs1_data[DIM_W-1:0];
            acc_dim_n <= n_ext[DIM_W-1:0];
            acc_dim_k <= rs2_data[DIM_W-1:0];
          end
          if (dec_start) begin
            state     <= ISSUE;
            stall_q   <= 1'b1;
            acc_start <= 1'b1;
            err       <= 1'b0;
          end
        end
        ISSUE: begin
          run_cnt <= 32'd1;
          state   <= WAIT;
        end
        WAIT: begin
          run_cnt <= next_cnt;
          if (acc_done) begin
            cycles_q <= next_cnt;
            stall_q  <= 1'b0;
            state    <= RELEASE;
          end else if (run_cnt == TIMEOUT_CNT) begin
            cycles_q <= next_cnt;
            stall_q  <= 1'b0;
            err      <= 1'b1;
            state    <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// Bench for gemm_issue_ctrl: vector table for IDLE-phase decode, hand sequences for
// runs/timeouts/reset, then random traffic checked against an arithmetic run model.
module tb_gemm_issue_ctrl;

  localparam int         TO  = 8;
  localparam logic [6:0] OPC = 7'b0001011;

  logic        clk;
  logic        rst;
  logic [31:0] inst_exec;
  logic        inst_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        acc_busy;
  logic        acc_done;
  logic        gemm_stall;
  logic        acc_start;
  logic [31:0] acc_addr_a, acc_addr_b, acc_addr_c;
  logic [15:0] acc_dim_m, acc_dim_n, acc_dim_k;
  logic        rd_wr;
  logic [31:0] rd_wdata;
  logic        err;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state: configuration, last run length and sticky timeout flag.
  logic [31:0] mA, mB, mC, mCycles;
  logic [15:0] mM, mN, mK;
  logic        mErr;

  logic [31:0] r1, r2;
  int          sel;

  typedef struct {
    logic        valid;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        done;
    logic        expStall;
    logic        expRdWr;
    logic [31:0] expRd;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expC;
    logic [15:0] expM;
    logic [15:0] expN;
    logic [15:0] expK;
  } vec_t;

  vec_t vecs[12];

  gemm_issue_ctrl #(.DIM_W(16), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_exec  (inst_exec),
    .inst_valid (inst_valid),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .acc_busy   (acc_busy),
    .acc_done   (acc_done),
    .gemm_stall (gemm_stall),
    .acc_start  (acc_start),
    .acc_addr_a (acc_addr_a),
    .acc_addr_b (acc_addr_b),
    .acc_addr_c (acc_addr_c),
    .acc_dim_m  (acc_dim_m),
    .acc_dim_n  (acc_dim_n),
    .acc_dim_k  (acc_dim_k),
    .rd_wr      (rd_wr),
    .rd_wdata   (rd_wdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic done, input logic busy);
    inst_valid = v;
    inst_exec  = {17'h0, f3, 5'h0, opc};
    rs1_data   = a;
    rs2_data   = b;
    acc_done   = done;
    acc_busy   = busy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic clearModel();
    mA = '0; mB = '0; mC = '0; mCycles = '0;
    mM = '0; mN = '0; mK = '0; mErr = 1'b0;
  endtask

  task automatic checkConfig(input string tag);
    checkOutput({tag, "_addr_a"}, acc_addr_a, mA);
    checkOutput({tag, "_addr_b"}, acc_addr_b, mB);
    checkOutput({tag, "_addr_c"}, acc_addr_c, mC);
    checkOutput({tag, "_dim_m"}, 32'(acc_dim_m), 32'(mM));
    checkOutput({tag, "_dim_n"}, 32'(acc_dim_n), 32'(mN));
    checkOutput({tag, "_dim_k"}, 32'(acc_dim_k), 32'(mK));
  endtask

  // Any non-START instruction while IDLE: single cycle, no stall, optional rd write.
  task automatic doIdleOp(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic busy);
    logic        isG;
    logic        expRdWr;
    logic [31:0] expRd;
    isG     = v && (opc == OPC);
    expRdWr = isG && (f3 == 3'd5 || f3 == 3'd6);
    expRd   = '0;
    if (expRdWr) expRd = (f3 == 3'd5) ? {29'b0, mErr, 1'b0, busy} : mCycles;
    applyStimulus(v, opc, f3, a, b, 1'b0, busy);
    checkOutput("idle_stall", 32'(gemm_stall), 32'(1'b0));
    checkOutput("idle_rd_wr", 32'(rd_wr), 32'(expRdWr));
    checkOutput("idle_rd_wdata", rd_wdata, expRd);
    tick();
    if (isG) begin
      case (f3)
        3'd0: mA = a;
        3'd1: mB = b == b ? a : a;
        3'd2: mC = a;
        3'd3: begin mM = a[15:0]; mN = a[31:16]; mK = b[15:0]; end
        default: ;
      endcase
    end
    checkOutput("idle_acc_start", 32'(acc_start), 32'(1'b0));
    checkOutput("idle_err", 32'(err), 32'(mErr));
    checkConfig("idle");
  endtask

  // START with acc_done arriving n cycles after acc_start; beyond TO it never arrives.
  task automatic runStart(input int n);
    int   ne;
    logic expErr;
    ne     = (n > TO) ? TO : n;
    expErr = (n > TO);
    applyStimulus(1'b1, OPC, 3'd4, $urandom, $urandom, 1'b0, 1'b0);
    checkOutput("start_stall_comb", 32'(gemm_stall), 32'(1'b1));
    checkOutput("start_rd_wr", 32'(rd_wr), 32'(1'b0));
    tick();
    for (int k = 1; k <= 2 + ne; k++) begin
      acc_done = (k == 1 + n);
      acc_busy = (k <= ne);
      #1;
      checkOutput("run_acc_start", 32'(acc_start), 32'(k == 1));
      checkOutput("run_stall", 32'(gemm_stall), 32'(k <= 1 + ne));
      checkOutput("run_err", 32'(err), 32'((k == 2 + ne) ? expErr : 1'b0));
      checkOutput("run_rd_wr", 32'(rd_wr), 32'(1'b0));
      if (k == 1) checkConfig("run_at_start");
      tick();
    end
    acc_done = 1'b0;
    acc_busy = 1'b0;
    mCycles  = 32'(ne + 1);
    mErr     = expErr;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 7'h0, 3'd0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    clearModel();
  endtask

  initial begin
    rst = 1'b0;
    clearModel();

    vecs[0]  = '{1'b1, OPC, 3'd0, 32'h1000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0};
    vecs[1]  = '{1'b1, OPC, 3'd3, 32'h0008_0004, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h0, 32'h0, 16'd4, 16'd8, 16'd16};
    vecs[2]  = '{1'b1, OPC, 3'd1, 32'h2000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h0, 16'd4, 16'd8, 16'd16};
    vecs[3]  = '{1'b1, OPC, 3'd2, 32'h3000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[4]  = '{1'b1, OPC, 3'd5, 32'hffff_ffff, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[5]  = '{1'b1, OPC, 3'd6, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[6]  = '{1'b1, OPC, 3'd7, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[7]  = '{1'b0, OPC, 3'd0, 32'hdead_beef, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[8]  = '{1'b1, 7'h33, 3'd3, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[9]  = '{1'b0, OPC, 3'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[10] = '{1'b1, OPC, 3'd7, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'd4, 16'd8, 16'd16};
    vecs[11] = '{1'b1, OPC, 3'd3, 32'h1234_5678, 32'habcd_9abc, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'h1000_0000, 32'h2000_0000, 32'h3000_0040, 16'h5678, 16'h1234, 16'h9abc};

    doReset();
    checkOutput("reset_stall", 32'(gemm_stall), 32'(1'b0));
    checkOutput("reset_acc_start", 32'(acc_start), 32'(1'b0));
    checkOutput("reset_rd_wr", 32'(rd_wr), 32'(1'b0));
    checkOutput("reset_rd_wdata", rd_wdata, 32'h0);
    checkOutput("reset_err", 32'(err), 32'(1'b0));
    checkConfig("reset");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].opc, vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].done, 1'b0);
      checkOutput($sformatf("vec%0d_stall", i), 32'(gemm_stall), 32'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d_rd_wr", i), 32'(rd_wr), 32'(vecs[i].expRdWr));
      checkOutput($sformatf("vec%0d_rd_wdata", i), rd_wdata, vecs[i].expRd);
      tick();
      checkOutput($sformatf("vec%0d_acc_start", i), 32'(acc_start), 32'(1'b0));
      checkOutput($sformatf("vec%0d_stall_after", i), 32'(gemm_stall), 32'(1'b0));
      checkOutput($sformatf("vec%0d_addr_a", i), acc_addr_a, vecs[i].expA);
      checkOutput($sformatf("vec%0d_addr_b", i), acc_addr_b, vecs[i].expB);
      checkOutput($sformatf("vec%0d_addr_c", i), acc_addr_c, vecs[i].expC);
      checkOutput($sformatf("vec%0d_dim_m", i), 32'(acc_dim_m), 32'(vecs[i].expM));
      checkOutput($sformatf("vec%0d_dim_n", i), 32'(acc_dim_n), 32'(vecs[i].expN));
      checkOutput($sformatf("vec%0d_dim_k", i), 32'(acc_dim_k), 32'(vecs[i].expK));
    end

    // Config immediately followed by START must be visible at acc_start.
    doReset();
    doIdleOp(1'b1, OPC, 3'd0, 32'h4000_0000, 32'h0, 1'b0);
    runStart(5);
    applyStimulus(1'b1, OPC, 3'd6, '0, '0, 1'b0, 1'b0);
    checkOutput("cycles_after_run", rd_wdata, 32'd6);
    tick();

    runStart(20);
    checkOutput("timeout_err_held", 32'(err), 32'(1'b1));
    applyStimulus(1'b1, OPC, 3'd5, '0, '0, 1'b0, 1'b0);
    checkOutput("status_after_timeout", rd_wdata, 32'h4);
    tick();
    applyStimulus(1'b1, OPC, 3'd6, '0, '0, 1'b0, 1'b0);
    checkOutput("cycles_after_timeout", rd_wdata, 32'd9);
    tick();
    runStart(TO);
    checkOutput("err_cleared_by_start", 32'(err), 32'(1'b0));

    // Reset in the middle of WAIT: back to IDLE, config and cycle count cleared.
    applyStimulus(1'b1, OPC, 3'd4, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_valid = 1'b0;
    #1;
    clearModel();
    checkOutput("midreset_stall", 32'(gemm_stall), 32'(1'b0));
    checkOutput("midreset_acc_start", 32'(acc_start), 32'(1'b0));
    checkOutput("midreset_err", 32'(err), 32'(1'b0));
    checkConfig("midreset");
    applyStimulus(1'b1, OPC, 3'd7, '0, '0, 1'b1, 1'b0);
    checkOutput("stray_done_stall", 32'(gemm_stall), 32'(1'b0));
    tick();
    checkOutput("stray_done_acc_start", 32'(acc_start), 32'(1'b0));
    applyStimulus(1'b1, OPC, 3'd6, '0, '0, 1'b0, 1'b0);
    checkOutput("cycles_after_midreset", rd_wdata, 32'h0);
    tick();

    for (int it = 0; it < 200; it++) begin
      sel = $urandom_range(0, 9);
      r1  = $urandom;
      r2  = $urandom;
      case (sel)
        0, 1, 2, 3: doIdleOp(1'b1, OPC, 3'(sel), r1, r2, 1'b0);
        4:          doIdleOp(1'b1, OPC, 3'd5, r1, r2, 1'($urandom_range(0, 1)));
        5:          doIdleOp(1'b1, OPC, 3'd6, r1, r2, 1'b0);
        6:          doIdleOp(1'b1, OPC, 3'd7, r1, r2, 1'b0);
        7:          doIdleOp(1'b0, OPC, 3'($urandom_range(0, 7)), r1, r2, 1'b0);
        8:          doIdleOp(1'b1, 7'h33, 3'($urandom_range(0, 7)), r1, r2, 1'b0);
        default:    runStart($urandom_range(1, 12));
      endcase
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/gemm_issue_ctrl.md
# gemm_issue_ctrl

Execute-stage controller that sequences the custom GEMM accelerator from the RISC-V pipeline. It decodes custom-0 instructions in execute, latches accelerator configuration from register operands, and launches a run. It also holds the pipeline stall for the whole run and returns status and cycle-count readback through the execute-stage writeback path. Its `gemm_stall` output is ORed with the hazard unit's `stall_sel` at the pipeline.

## Interface
Parameters:
- `DIM_W`, default 16: width of each of the M/N/K dimension fields.
- `TIMEOUT`, default 65535: maximum cycles spent in WAIT before the controller aborts.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_exec`  in  32  instruction currently in execute.
- `inst_valid`  in  1  execute slot holds a real instruction (0 for a bubble or a flushed slot).
- `rs1_data`  in  32  forwarded rs1 operand.
- `rs2_data`  in  32  forwarded rs2 operand.
- `acc_busy`  in  1  accelerator running.
- `acc_done`  in  1  one-cycle completion pulse.
- `gemm_stall`  out  1  freeze the fetch, decode and execute stages.
- `acc_start`  out  1  one-cycle launch pulse.
- `acc_addr_a`, `acc_addr_b`, `acc_addr_c`  out  32  each: matrix base addresses.
- `acc_dim_m`, `acc_dim_n`, `acc_dim_k`  out  DIM_W  each: matrix dimensions.
- `rd_wr`  out  1  controller drives the rd write this cycle.
- `rd_wdata`  out  32  rd write value.
- `err`  out  1  sticky timeout flag.

## Operation
- Decode: a GEMM op requires `inst_valid=1` and `inst_exec[6:0]=7'b0001011`. The operation is selected by funct3 `inst_exec[14:12]`:
  - 000 CFG_A: `acc_addr_a`←rs1.
  - 001 CFG_B: `acc_addr_b`←rs1.
  - 010 CFG_C: `acc_addr_c`←rs1.
  - 011 CFG_DIM: M←rs1[DIM_W-1:0], N←rs1[31:16] (truncated/zero-extended to DIM_W), K←rs2[DIM_W-1:0].
  - 100 START: launch a run.
  - 101 STATUS: rd←{29'b0, err, state!=IDLE, acc_busy}.
  - 110 CYCLES: rd←cycle count of the last completed or aborted run.
  - 111: no operation; no register change and no stall.
- CFG, STATUS and CYCLES act only in IDLE and take a single cycle. STATUS and CYCLES assert `rd_wr` combinationally in that same cycle.
- State machine:
  - IDLE: START decoded → ISSUE. `gemm_stall` asserts combinationally in the same cycle.
  - ISSUE: `acc_start`=1 for exactly this cycle; the run counter loads 1; → WAIT.
  - WAIT: the run counter increments each cycle.
    - `acc_done`=1 → RELEASE, and the final count is latched into the CYCLES register.
    - Otherwise, counter == TIMEOUT → RELEASE, `err`←1, and the count is latched.
  - RELEASE: `gemm_stall`=0 for one cycle so the START instruction leaves execute. Decode is ignored this cycle, so the instruction is not re-issued. → IDLE.
- `gemm_stall` = (IDLE & START decoded) | ISSUE | WAIT.
- `err` is cleared on every IDLE→ISSUE transition and by reset.
- Run counter width is 32 bits and saturates at all-ones.
- `acc_done` outside WAIT is ignored. If `acc_done` and the timeout occur in the same cycle, `acc_done` wins and `err` stays 0.

## Timing
- Reset values:
  - FSM=IDLE.
  - `gemm_stall`=0, `acc_start`=0, `rd_wr`=0, `rd_wdata`=0, `err`=0.
  - All address and dimension registers = 0.
  - CYCLES register = 0.
- Reset asserted mid-run returns to IDLE on the next edge and drops the stall. No `acc_start` is generated; the accelerator is reset separately.
- CFG writes are visible on the outputs the cycle after the instruction sits in execute. A CFG immediately followed by START is therefore seen by the accelerator at the `acc_start` cycle.
- Launch latency: START in execute at cycle t → `acc_start` at t+1. With `acc_done` at t+1+n (n≥1), the stall is high through t+1+n, RELEASE occurs at t+2+n, and CYCLES = n+1.
- Minimum START occupancy is 4 cycles (IDLE, ISSUE, WAIT, RELEASE).
- `rd_wr` and `rd_wdata` are combinational from decode and state. All other outputs are registered, except `gemm_stall`, which is combinational in IDLE.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → all outputs 0 and FSM IDLE. Then issue STATUS → `rd_wdata`=0.
- Config: CFG_A rs1=0x1000_0000, CFG_DIM rs1=0x0008_0004 rs2=0x0010 → `acc_addr_a`=0x1000_0000, M=4, N=8, K=16 one cycle later. No stall at any point.
- Run: START at t, `acc_done` pulse at t+6 → `acc_start` only at t+1, stall high t..t+6, low at t+7. A following CYCLES read → 6.
- Timeout: TIMEOUT=8 with `acc_done` never asserted → stall released after WAIT count 8 and `err`=1. A following STATUS read → 0x4. The next START clears `err`.
- Bubble/flush: `inst_valid`=0 with a START encoding → no stall and no `acc_start`. A stray `acc_done` in IDLE → no state change.
- Reset mid-WAIT: `rst`=1 at t+3 of a run → IDLE and stall 0 at t+4. A later `acc_done` is ignored and the CYCLES register is 0.
